multi_osc_nco: RTL and testbench
================================

Name: multi_osc_nco

Overview:
- Parametrised multi-channel successor to the single-channel oscillator datapath.
- Holds one phase accumulator per channel and advances all enabled channels once per sample tick.
- Per channel and tick: reads the sine LUT, then sends a 24-bit command word to the SPI DAC driver using a ready/busy handshake.
- Sits between the ADC/control frequency source, the SineLUT and DAC_SPI_Out. Replaces the inline timer/phase logic in the top level.

Parameters:
- CHANNELS, 4, number of oscillator channels (1..4, one DAC channel each).
- PHASE_W, 16, phase accumulator and frequency word width.
- PHASE_MOD, 44000, accumulator modulus; phase wraps in [0, PHASE_MOD-1].
- ADDR_W, 11, LUT address width.
- ADDR_SHIFT, 5, right shift applied to phase to form the LUT address.
- SAMPLE_INTERVAL, 2015, clock cycles per sample tick (tick period = SAMPLE_INTERVAL exactly).
- LUT_LATENCY, 1, clock edges from an lut_addr update to a valid lut_value (1..3).
- FREQ_MAX, 1000, written frequency above this sets freq_err.
- CMD_BASE, 4'b0011, upper command nibble of the DAC word.

Ports:
- clock_in  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- freq_wr  in  1  one-cycle strobe: write freq_data into the shadow register of freq_chan
- freq_chan  in  2  target channel for freq_wr
- freq_data  in  PHASE_W  frequency increment
- chan_enable  in  CHANNELS  per-channel enable
- phase_clr  in  1  one-cycle strobe: zero all phase accumulators
- err_clr  in  1  clears overrun and freq_err
- lut_addr  out  ADDR_W  sine LUT address
- lut_value  in  16  sine LUT data
- dac_data  out  24  {CMD_BASE, one-hot channel[3:0], sample[15:0]}
- dac_send  out  1  one-cycle send pulse to the DAC driver
- dac_busy  in  1  DAC driver busy
- overrun  out  1  sticky: a tick arrived while a sequence was still active
- freq_err  out  1  sticky: written frequency exceeded FREQ_MAX

Behaviour:
- Reset: all outputs 0. Timer, phases, shadow and active frequencies 0. FSM in IDLE.
- Timer counts 0..SAMPLE_INTERVAL-1. Tick asserts in the cycle the count equals SAMPLE_INTERVAL-1; the count then wraps to 0.
- Frequency write: freq_wr stores into shadow[freq_chan], clamped to PHASE_MOD-1.
  - freq_err sets if the unclamped value > FREQ_MAX.
  - freq_chan >= CHANNELS: write ignored, freq_err unaffected.
- On tick with FSM in IDLE:
  - All shadows copy to active frequencies (no mid-sequence tearing).
  - FSM -> ADDR with ch = lowest enabled channel.
  - If no channel is enabled, FSM stays IDLE.
- FSM states:
  - IDLE: wait for tick.
  - ADDR:
    - lut_addr <= phase[ch] >> ADDR_SHIFT (pre-increment phase).
    - phase[ch] <= phase[ch] + freq[ch], computed in PHASE_W+1 bits; subtract PHASE_MOD if the sum >= PHASE_MOD.
    - -> WAIT.
  - WAIT:
    - Count LUT_LATENCY edges, then latch dac_data <= {CMD_BASE, 1<<ch, lut_value}.
    - -> SEND.
  - SEND: when dac_busy = 0, pulse dac_send for exactly one cycle, then -> HOLD. While dac_busy = 1, hold without pulsing.
  - HOLD:
    - Wait one cycle for the driver to raise busy, then wait for dac_busy = 0.
    - Then -> ADDR for the next enabled channel above ch, or -> IDLE if none remain.
- Disabled channels are skipped: no LUT read, no send, phase held.
- dac_data holds its value between sends.
- Tick while FSM is not IDLE: tick dropped, overrun sets, current sequence continues, shadows are not copied.
- phase_clr: all phases <= 0 on the next edge; it overrides any same-cycle ADDR update.
- err_clr: clears both flags. A same-cycle set event wins over the clear.
- rstn asserted mid-sequence: immediate return to the reset state. Any dac_send pulse in progress is cut off. No partial resend after reset.

Test Plan:
- Reset, CHANNELS=1, freq 100 on ch0, dac_busy tied 0 -> one dac_send per 2015 cycles.
  - dac_data[23:16] = 8'h31.
  - lut_addr sequence 0, 3, 6 (phase 0, 100, 200 >> 5).
- Wrap: freq 43990 on ch0, run two ticks -> phase sequence 0, 43990, 43980; lut_addr = 1374 after the second tick.
- Four channels enabled, chan_enable = 4'b1010 -> only ch1 and ch3 send.
  - Command bytes 8'h32 then 8'h38, in that order, each tick.
  - Phases of ch0 and ch2 are unchanged.
- dac_busy held high for 3000 cycles -> no dac_send while busy; overrun = 1 at the next tick; err_clr returns overrun to 0.
- freq_wr of 1500 to ch2 mid-sequence -> freq_err = 1; the new value is used only from the tick after the current sequence ends.
- phase_clr coinciding with ADDR of ch0 -> phase[ch0] = 0 afterwards.
- rstn pulse in WAIT -> all outputs 0 and FSM in IDLE.

Source files
------------

// File: rtl/multi_osc_nco.sv
// Multi-channel NCO: per-channel phase accumulators advanced once per sample tick,
// each enabled channel reads the sine LUT and pushes one 24-bit word to the SPI DAC.
module multi_osc_nco #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned PHASE_W         = 16,
    parameter int unsigned PHASE_MOD       = 44000,
    parameter int unsigned ADDR_W          = 11,
    parameter int unsigned ADDR_SHIFT      = 5,
    parameter int unsigned SAMPLE_INTERVAL = 2015,
    parameter int unsigned LUT_LATENCY     = 1,
    parameter int unsigned FREQ_MAX        = 1000,
    parameter logic [3:0]  CMD_BASE        = 4'b0011
) (
    input  logic                clock_in,
    input  logic                rstn,
    input  logic                freq_wr,
    input  logic [1:0]          freq_chan,
    input  logic [PHASE_W-1:0]  freq_data,
    input  logic [CHANNELS-1:0] chan_enable,
    input  logic                phase_clr,
    input  logic                err_clr,
    output logic [ADDR_W-1:0]   lut_addr,
    input  logic [15:0]         lut_value,
    output logic [23:0]         dac_data,
    output logic                dac_send,
    input  logic                dac_busy,
    output logic                overrun,
    output logic                freq_err
);

    localparam int unsigned        TW         = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
    localparam logic [TW-1:0]      TICK_AT    = TW'(SAMPLE_INTERVAL - 1);
    localparam logic [PHASE_W:0]   MOD_EXT    = (PHASE_W+1)'(PHASE_MOD);
    localparam logic [PHASE_W-1:0] FREQ_CLAMP = PHASE_W'(PHASE_MOD - 1);
    localparam logic [1:0]         LAT        = 2'(LUT_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_SEND,
        S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       cnt_q, cnt_d;
    logic [1:0]          ch_q, ch_d;
    logic [1:0]          wait_q, wait_d;
    logic                hold_q, hold_d;
    logic [PHASE_W-1:0]  phase_q  [CHANNELS];
    logic [PHASE_W-1:0]  phase_d  [CHANNELS];
    logic [PHASE_W-1:0]  freq_q   [CHANNELS];
    logic [PHASE_W-1:0]  freq_d   [CHANNELS];
    logic [PHASE_W-1:0]  shadow_q [CHANNELS];
    logic [PHASE_W-1:0]  shadow_d [CHANNELS];
    logic [ADDR_W-1:0]   lut_addr_q, lut_addr_d;
    logic [23:0]         dac_data_q, dac_data_d;
    logic                dac_send_q, dac_send_d;
    logic                overrun_q, overrun_d;
    logic                freq_err_q, freq_err_d;

    logic                tick;
    logic                chan_ok;
    logic                freq_big;
    logic [3:0]          onehot;
    logic [PHASE_W:0]    sum;
    logic [PHASE_W-1:0]  phase_next;
    logic                first_found, next_found;
    logic [1:0]          first_ch, next_ch;

    assign tick     = (cnt_q == TICK_AT);
    assign chan_ok  = ({1'b0, freq_chan} < 3'(CHANNELS));
    assign freq_big = (32'(freq_data) > FREQ_MAX);
    assign onehot   = 4'b0001 << ch_q;

    // Sum is one bit wider so a single conditional subtract implements the modulus.
    always_comb begin
        sum        = {1'b0, phase_q[ch_q]} + {1'b0, freq_q[ch_q]};
        phase_next = (sum >= MOD_EXT) ? PHASE_W'(sum - MOD_EXT) : PHASE_W'(sum);
    end

    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        next_found  = 1'b0;
        next_ch     = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (chan_enable[i] && !first_found) begin
                first_found = 1'b1;
                first_ch    = 2'(i);
            end
            if (chan_enable[i] && !next_found && (i > 32'(ch_q))) begin
                next_found = 1'b1;
                next_ch    = 2'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = tick ? '0 : cnt_q + TW'(1);
        ch_d       = ch_q;
        wait_d     = wait_q;
        hold_d     = hold_q;
        phase_d    = phase_q;
        freq_d     = freq_q;
        shadow_d   = shadow_q;
        lut_addr_d = lut_addr_q;
        dac_data_d = dac_data_q;
        dac_send_d = 1'b0;
        overrun_d  = overrun_q;
        freq_err_d = freq_err_q;

        if (err_clr) begin
            overrun_d  = 1'b0;
            freq_err_d = 1'b0;
        end

        if (freq_wr && chan_ok) begin
            shadow_d[freq_chan] = (freq_data > FREQ_CLAMP) ? FREQ_CLAMP : freq_data;
            if (freq_big) freq_err_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (tick) begin
                    freq_d = shadow_q;
                    if (first_found) begin
                        ch_d    = first_ch;
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                lut_addr_d     = ADDR_W'(phase_q[ch_q] >> ADDR_SHIFT);
                phase_d[ch_q]  = phase_next;
                wait_d         = '0;
                state_d        = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == LAT) begin
                    dac_data_d = {CMD_BASE, onehot, lut_value};
                    state_d    = S_SEND;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_SEND: begin
                if (!dac_busy) begin
                    dac_send_d = 1'b1;
                    hold_d     = 1'b0;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                // First HOLD cycle gives the driver time to raise busy.
                if (!hold_q) begin
                    hold_d = 1'b1;
                end else if (!dac_busy) begin
                    if (next_found) begin
                        ch_d    = next_ch;
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (tick && (state_q != S_IDLE)) overrun_d = 1'b1;

        if (phase_clr) begin
            for (int unsigned i = 0; i < CHANNELS; i++) phase_d[i] = '0;
        end
    end

    always_ff @(posedge clock_in or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ch_q       <= '0;
            wait_q     <= '0;
            hold_q     <= 1'b0;
            phase_q    <= '{default: '0};
            freq_q     <= '{default: '0};
            shadow_q   <= '{default: '0};
            lut_addr_q <= '0;
            dac_data_q <= '0;
            dac_send_q <= 1'b0;
            overrun_q  <= 1'b0;
            freq_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            wait_q     <= wait_d;
            hold_q     <= hold_d;
            phase_q    <= phase_d;
            freq_q     <= freq_d;
            shadow_q   <= shadow_d;
            lut_addr_q <= lut_addr_d;
            dac_data_q <= dac_data_d;
            dac_send_q <= dac_send_d;
            overrun_q  <= overrun_d;
            freq_err_q <= freq_err_d;
        end
    end

    assign lut_addr = lut_addr_q;
    assign dac_data = dac_data_q;
    assign dac_send = dac_send_q;
    assign overrun  = overrun_q;
    assign freq_err = freq_err_q;

endmodule

// File: tb/tb_multi_osc_nco.sv
// Directed bench for multi_osc_nco: registered LUT model, send monitor, one task per scenario.
module tb_multi_osc_nco;

    logic        clk = 1'b0;
    logic        rstn;
    logic        freq_wr, phase_clr, err_clr, dac_busy;
    logic [1:0]  freq_chan;
    logic [15:0] freq_data;
    logic [3:0]  chan_enable;
    logic [10:0] lut_addr;
    logic [15:0] lut_value = '0;
    logic [23:0] dac_data;
    logic        dac_send, overrun, freq_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [23:0] sd_q[$];
    logic [10:0] sa_q[$];
    int          sc_q[$];

    multi_osc_nco dut (
        .clock_in    (clk),
        .rstn        (rstn),
        .freq_wr     (freq_wr),
        .freq_chan   (freq_chan),
        .freq_data   (freq_data),
        .chan_enable (chan_enable),
        .phase_clr   (phase_clr),
        .err_clr     (err_clr),
        .lut_addr    (lut_addr),
        .lut_value   (lut_value),
        .dac_data    (dac_data),
        .dac_send    (dac_send),
        .dac_busy    (dac_busy),
        .overrun     (overrun),
        .freq_err    (freq_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lutf(input logic [10:0] a);
        return {5'b10100, a};
    endfunction

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        lut_value <= lutf(lut_addr);
    end

    always @(negedge clk) begin
        if (rstn === 1'b1 && dac_send === 1'b1) begin
            sd_q.push_back(dac_data);
            sa_q.push_back(lut_addr);
            sc_q.push_back(cyc);
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0; freq_wr = 1'b0; phase_clr = 1'b0; err_clr = 1'b0; dac_busy = 1'b0;
        freq_chan = '0; freq_data = '0; chan_enable = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wfreq(input logic [1:0] ch, input logic [15:0] v);
        freq_wr = 1'b1; freq_chan = ch; freq_data = v;
        @(negedge clk);
        freq_wr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rstn = 1'b0;
        #1;
        n_checks++; if (lut_addr !== 11'd0) begin n_fail++; $display("FAIL reset_lut_addr: got %0d expected 0", lut_addr); end
        n_checks++; if (dac_data !== 24'd0) begin n_fail++; $display("FAIL reset_dac_data: got %h expected 0", dac_data); end
        n_checks++; if (dac_send !== 1'b0) begin n_fail++; $display("FAIL reset_dac_send: got %b expected 0", dac_send); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_checks++; if (freq_err !== 1'b0) begin n_fail++; $display("FAIL reset_freq_err: got %b expected 0", freq_err); end
    endtask

    task automatic test_single_channel();
        int t0, base, n;
        int ea [3] = '{0, 3, 6};
        do_reset();
        t0 = cyc;
        chan_enable = 4'b0001;
        wfreq(2'd0, 16'd100);
        base = sd_q.size();
        wait_until(t0 + 3 * 2015 + 20);
        n = sd_q.size() - base;
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL single_count: got %0d expected 3", n); end
        if (n > 0) begin
            n_checks++;
            if (sc_q[base] - t0 < 2016 || sc_q[base] - t0 > 2030) begin
                n_fail++; $display("FAIL single_first_send_cycle: got %0d expected 2016..2030", sc_q[base] - t0);
            end
        end
        for (int k = 0; k < 3 && k < n; k++) begin
            n_checks++; if (sd_q[base+k][23:16] !== 8'h31) begin n_fail++; $display("FAIL single_cmd[%0d]: got %h expected 31", k, sd_q[base+k][23:16]); end
            n_checks++; if (sa_q[base+k] !== 11'(ea[k])) begin n_fail++; $display("FAIL single_addr[%0d]: got %0d expected %0d", k, sa_q[base+k], ea[k]); end
            n_checks++; if (sd_q[base+k][15:0] !== lutf(11'(ea[k]))) begin n_fail++; $display("FAIL single_sample[%0d]: got %h expected %h", k, sd_q[base+k][15:0], lutf(11'(ea[k]))); end
            if (k > 0) begin
                n_checks++;
                if (sc_q[base+k] - sc_q[base+k-1] !== 2015) begin
                    n_fail++; $display("FAIL single_period[%0d]: got %0d expected 2015", k, sc_q[base+k] - sc_q[base+k-1]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int t0, base, n;
        int ea [3] = '{0, 1374, 1374};
        do_reset();
        t0 = cyc;
        chan_enable = 4'b0001;
        wfreq(2'd0, 16'd43990);
        base = sd_q.size();
        wait_until(t0 + 3 * 2015 + 20);
        n = sd_q.size() - base;
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL wrap_count: got %0d expected 3", n); end
        for (int k = 0; k < 3 && k < n; k++) begin
            n_checks++; if (sa_q[base+k] !== 11'(ea[k])) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", k, sa_q[base+k], ea[k]); end
        end
    endtask

    task automatic test_skip_disabled();
        int t0, base, n;
        logic [7:0] ec [8] = '{8'h32, 8'h38, 8'h32, 8'h38, 8'h31, 8'h32, 8'h34, 8'h38};
        int         ea [8] = '{0, 0, 6, 12, 0, 12, 0, 25};
        do_reset();
        t0 = cyc;
        chan_enable = 4'b1010;
        wfreq(2'd0, 16'd100);
        wfreq(2'd1, 16'd200);
        wfreq(2'd2, 16'd300);
        wfreq(2'd3, 16'd400);
        base = sd_q.size();
        wait_until(t0 + 2 * 2015 + 40);
        chan_enable = 4'b1111;
        wait_until(t0 + 3 * 2015 + 60);
        n = sd_q.size() - base;
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL skip_count: got %0d expected 8", n); end
        for (int k = 0; k < 8 && k < n; k++) begin
            n_checks++; if (sd_q[base+k][23:16] !== ec[k]) begin n_fail++; $display("FAIL skip_cmd[%0d]: got %h expected %h", k, sd_q[base+k][23:16], ec[k]); end
            n_checks++; if (sa_q[base+k] !== 11'(ea[k])) begin n_fail++; $display("FAIL skip_addr[%0d]: got %0d expected %0d", k, sa_q[base+k], ea[k]); end
        end
    endtask

    task automatic test_busy_overrun();
        int t0, base, n;
        do_reset();
        t0 = cyc;
        chan_enable = 4'b0001;
        wfreq(2'd0, 16'd100);
        wait_until(t0 + 1500);
        dac_busy = 1'b1;
        base = sd_q.size();
        wait_until(t0 + 4000);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL busy_overrun_early: got %b expected 0", overrun); end
        wait_until(t0 + 4040);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL busy_overrun_set: got %b expected 1", overrun); end
        wait_until(t0 + 4499);
        n = sd_q.size() - base;
        n_checks++; if (n !== 0) begin n_fail++; $display("FAIL busy_no_send: got %0d sends expected 0", n); end
        dac_busy = 1'b0;
        wait_until(t0 + 4520);
        n = sd_q.size() - base;
        n_checks++; if (n !== 1) begin n_fail++; $display("FAIL busy_release_send: got %0d sends expected 1", n); end
        if (n > 0) begin
            n_checks++; if (sa_q[base] !== 11'd0) begin n_fail++; $display("FAIL busy_release_addr: got %0d expected 0", sa_q[base]); end
        end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL busy_overrun_sticky: got %b expected 1", overrun); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL busy_overrun_clr: got %b expected 0", overrun); end
    endtask

    task automatic test_freq_err();
        int t0, base, n, lim;
        logic [7:0] ec [6] = '{8'h31, 8'h34, 8'h31, 8'h34, 8'h31, 8'h34};
        int         ea [6] = '{0, 0, 2, 3, 4, 50};
        do_reset();
        wfreq(2'd1, 16'd1000);
        n_checks++; if (freq_err !== 1'b0) begin n_fail++; $display("FAIL ferr_at_max: got %b expected 0", freq_err); end
        wfreq(2'd1, 16'd1001);
        n_checks++; if (freq_err !== 1'b1) begin n_fail++; $display("FAIL ferr_above_max: got %b expected 1", freq_err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++; if (freq_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clr: got %b expected 0", freq_err); end
        err_clr = 1'b1;
        wfreq(2'd1, 16'd1500);
        err_clr = 1'b0;
        n_checks++; if (freq_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set_wins: got %b expected 1", freq_err); end

        do_reset();
        t0 = cyc;
        chan_enable = 4'b0101;
        wfreq(2'd0, 16'd64);
        wfreq(2'd2, 16'd100);
        base = sd_q.size();
        lim = t0 + 2100;
        while (dac_send !== 1'b1 && cyc < lim) @(negedge clk);
        n_checks++; if (dac_send !== 1'b1) begin n_fail++; $display("FAIL ferr_seq_start: got no send by cycle %0d expected a send", cyc - t0); end
        wfreq(2'd2, 16'd1500);
        n_checks++; if (freq_err !== 1'b1) begin n_fail++; $display("FAIL ferr_mid_seq: got %b expected 1", freq_err); end
        wait_until(t0 + 3 * 2015 + 30);
        n = sd_q.size() - base;
        n_checks++; if (n !== 6) begin n_fail++; $display("FAIL ferr_count: got %0d expected 6", n); end
        for (int k = 0; k < 6 && k < n; k++) begin
            n_checks++; if (sd_q[base+k][23:16] !== ec[k]) begin n_fail++; $display("FAIL ferr_cmd[%0d]: got %h expected %h", k, sd_q[base+k][23:16], ec[k]); end
            n_checks++; if (sa_q[base+k] !== 11'(ea[k])) begin n_fail++; $display("FAIL ferr_addr[%0d]: got %0d expected %0d", k, sa_q[base+k], ea[k]); end
        end
    endtask

    task automatic test_phase_clr();
        int t0, base, n;
        int ea [3] = '{0, 31, 0};
        do_reset();
        t0 = cyc;
        chan_enable = 4'b0001;
        wfreq(2'd0, 16'd1000);
        base = sd_q.size();
        wait_until(t0 + 4030);
        phase_clr = 1'b1;
        @(negedge clk);
        phase_clr = 1'b0;
        wait_until(t0 + 3 * 2015 + 20);
        n = sd_q.size() - base;
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL pclr_count: got %0d expected 3", n); end
        for (int k = 0; k < 3 && k < n; k++) begin
            n_checks++; if (sa_q[base+k] !== 11'(ea[k])) begin n_fail++; $display("FAIL pclr_addr[%0d]: got %0d expected %0d", k, sa_q[base+k], ea[k]); end
        end
    endtask

    task automatic test_reset_mid_seq();
        int t0, t1, base, n;
        do_reset();
        t0 = cyc;
        chan_enable = 4'b0001;
        wfreq(2'd0, 16'd100);
        wfreq(2'd1, 16'd1001);
        wait_until(t0 + 4031);
        n_checks++; if (lut_addr !== 11'd3) begin n_fail++; $display("FAIL rst_pre_addr: got %0d expected 3", lut_addr); end
        rstn = 1'b0;
        #1;
        n_checks++; if (lut_addr !== 11'd0) begin n_fail++; $display("FAIL rst_mid_lut_addr: got %0d expected 0", lut_addr); end
        n_checks++; if (dac_data !== 24'd0) begin n_fail++; $display("FAIL rst_mid_dac_data: got %h expected 0", dac_data); end
        n_checks++; if (dac_send !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dac_send: got %b expected 0", dac_send); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overrun: got %b expected 0", overrun); end
        n_checks++; if (freq_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_freq_err: got %b expected 0", freq_err); end
        @(negedge clk);
        rstn = 1'b1;
        t1 = cyc;
        base = sd_q.size();
        wait_until(t1 + 2010);
        n = sd_q.size() - base;
        n_checks++; if (n !== 0) begin n_fail++; $display("FAIL rst_no_resend: got %0d sends expected 0", n); end
        wait_until(t1 + 2040);
        n = sd_q.size() - base;
        n_checks++; if (n !== 1) begin n_fail++; $display("FAIL rst_next_send: got %0d sends expected 1", n); end
        if (n > 0) begin
            n_checks++; if (sa_q[base] !== 11'd0) begin n_fail++; $display("FAIL rst_next_addr: got %0d expected 0", sa_q[base]); end
            n_checks++; if (sd_q[base][23:16] !== 8'h31) begin n_fail++; $display("FAIL rst_next_cmd: got %h expected 31", sd_q[base][23:16]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_wrap();
        test_skip_disabled();
        test_busy_overrun();
        test_freq_err();
        test_phase_clr();
        test_reset_mid_seq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
